// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter with a small transmit FIFO. Bytes enter
//               over a valid/ready handshake. Each byte is sent as one start
//               bit, 8 data bits LSB first, an optional even-parity bit and
//               NSTOP stop bits. Frames go out back to back while the FIFO
//               holds data.
//
// Ports       : clk        - transmit clock (21.477 MHz)
//               rst        - asynchronous, active-high reset
//               tx_DI      - byte to transmit
//               tx_valid   - tx_DI is valid this cycle
//               tx_ready   - FIFO can accept a byte this cycle (combinational)
//               uart_DO    - serial line to the FTDI RX pin (registered)
//               tx_busy    - frame on the line or FIFO non-empty (registered)
//               fifo_count - bytes currently held in the FIFO
//
// Option      : define UART_TX_PARITY_EN to insert an even-parity bit
//               between the data bits and the stop bits.
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int NCLKS_PER_BIT = 186,  // clock cycles per serial bit, >= 2
    parameter int NSTOP         = 2,    // stop bits, 1 or 2
    parameter int FIFO_DEPTH    = 16,   // power of two, >= 2
    parameter int SPACE         = 1     // idle / stop / logic-1 line level
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_DI,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_DO,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_AW + 1;
    // The bit counter must reach the end of the whole stop period.
    localparam int c_TW = $clog2(NSTOP * NCLKS_PER_BIT);

    localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(NCLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0] c_STOP_LAST = c_TW'(NSTOP * NCLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(FIFO_DEPTH);
    localparam logic            c_MARK      = (SPACE != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and pointers
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    // Serialiser
    state_t          r_state;
    logic [c_TW-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_uart;
    logic            r_busy;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
`endif

    logic            w_push;
    logic            w_pop;
    logic            w_nempty;
    logic            w_bit_end;
    logic            w_stop_end;
    logic [7:0]      w_head;

    // Line level for a data value: logic 1 is sent as SPACE.
    function automatic logic f_level(input logic b);
        return b ? c_MARK : ~c_MARK;
    endfunction

    assign tx_ready   = (r_count < c_DEPTH) && !rst;
    assign w_push     = tx_valid && tx_ready;
    assign w_nempty   = (r_count != '0);
    assign w_bit_end  = (r_cnt == c_BIT_LAST);
    assign w_stop_end = (r_cnt == c_STOP_LAST);
    assign w_head     = r_mem[r_rd_ptr];

    // A byte leaves the FIFO only when the serialiser loads it. The decision
    // uses the registered count, so a byte written this edge waits one edge.
    assign w_pop = w_nempty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_stop_end));

    assign uart_DO    = r_uart;
    assign tx_busy    = r_busy;
    assign fifo_count = r_count;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_DI;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM with registered line and busy outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_uart    <= c_MARK;
            r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_uart <= c_MARK;
                    r_busy <= 1'b0;
                    if (w_nempty) begin
                        r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                        r_uart   <= ~c_MARK;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_uart    <= f_level(r_shift[0]);
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_TW'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_uart  <= f_level(r_parity);
                            r_state <= S_PARITY;
`else
                            r_uart  <= c_MARK;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_uart    <= f_level(r_shift[1]);
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_TW'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_uart  <= c_MARK;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + c_TW'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (w_stop_end) begin
                        r_cnt <= '0;
                        if (w_nempty) begin
                            // Next byte waiting: start bit follows the last
                            // stop bit directly, with no idle gap.
                            r_shift  <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                            r_uart   <= ~c_MARK;
                            r_state  <= S_START;
                        end else begin
                            r_uart  <= c_MARK;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_TW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_uart  <= c_MARK;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx. The driver pushes each byte it
//               expects the design to accept into a queue together with the
//               earliest cycle its start bit may appear. A line monitor
//               captures every frame sample by sample and compares it with
//               the ideal waveform built from the byte. Busy, FIFO occupancy
//               and ready are compared with a queue-level model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int NCLKS   = 4;
    localparam int NSTOP_P = 2;
    localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 1 + 8 + 1 + NSTOP_P;
`else
    localparam int NBITS = 1 + 8 + NSTOP_P;
`endif
    localparam int FRAME = NBITS * NCLKS;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] tx_DI    = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       uart_DO;
    logic       tx_busy;
    logic [2:0] fifo_count;

    uart_tx #(
        .NCLKS_PER_BIT(NCLKS),
        .NSTOP        (NSTOP_P),
        .FIFO_DEPTH   (DEPTH),
        .SPACE        (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_DI     (tx_DI),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .uart_DO   (uart_DO),
        .tx_busy   (tx_busy),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         earliest;
    } exp_t;

    exp_t q[$];
    int   cyc        = 0;
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   n_acc      = 0;   // bytes accepted since last reset
    int   n_started  = 0;   // frames whose start bit has appeared
    int   prev_start = -100000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Ideal line waveform, one entry per clock: start 0, data LSB first,
    // optional even parity, then stop bits at 1.
    function automatic logic [FRAME-1:0] frame_of(input logic [7:0] b);
        logic [FRAME-1:0] f;
        int               k;
        logic             v;
        f = '0;
        for (int s = 0; s < FRAME; s++) begin
            k = s / NCLKS;
            if (k == 0)      v = 1'b0;
            else if (k <= 8) v = b[k-1];
`ifdef UART_TX_PARITY_EN
            else if (k == 9) v = ^b;
`endif
            else             v = 1'b1;
            f[s] = v;
        end
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Line monitor / scoreboard
    // ------------------------------------------------------------------
    logic             m_active = 1'b0;
    int               m_s      = 0;
    logic [FRAME-1:0] m_act;
    logic [FRAME-1:0] m_exp;
    exp_t             m_e;
    logic             m_busy;
    int               m_start_exp;

    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else begin
            if (!m_active) begin
                if (q.size() == 0) begin
                    check("idle_line", uart_DO, 1);
                end else if (uart_DO == 1'b0) begin
                    m_e         = q.pop_front();
                    m_start_exp = (m_e.earliest > prev_start + FRAME) ? m_e.earliest
                                                                      : prev_start + FRAME;
                    check("start_cycle", cyc, m_start_exp);
                    m_exp      = frame_of(m_e.data);
                    m_act      = '0;
                    m_s        = 0;
                    m_active   = 1'b1;
                    prev_start = cyc;
                    n_started++;
                end
            end
            m_busy = m_active;
            if (m_active) begin
                m_act[m_s] = uart_DO;
                m_s++;
                if (m_s == FRAME) begin
                    check($sformatf("frame_%02h", m_e.data), m_act, m_exp);
                    m_active = 1'b0;
                end
            end
            check("tx_busy", tx_busy, m_busy);
            check("fifo_count", fifo_count, n_acc - n_started);
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic [7:0] d, output logic acc);
        logic exp_ready;
        exp_t e;
        @(negedge clk);
        tx_valid = v;
        tx_DI    = d;
        #1;
        exp_ready = ((n_acc - n_started) < DEPTH);
        check("tx_ready", tx_ready, exp_ready);
        acc = v && exp_ready;
        if (acc) begin
            // Pushed at the coming edge, eligible to start one edge later.
            e.data     = d;
            e.earliest = cyc + 2;
            q.push_back(e);
            n_acc++;
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, a);
    endtask

    task automatic drain(input int budget);
        int   n;
        logic a;
        n = 0;
        while ((q.size() != 0 || m_active || n_acc != n_started) && n < budget) begin
            drive(1'b0, 8'h00, a);
            n++;
        end
        check("drain_done", (n < budget), 1);
        idle(4);
    endtask

    task automatic async_reset(input int hold);
        #2 rst = 1'b1;
        #1;
        check("rst_uart_DO", uart_DO, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_tx_ready", tx_ready, 0);
        q.delete();
        n_acc      = 0;
        n_started  = 0;
        prev_start = -100000;
        repeat (hold) @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int   idx;

        // Power-on reset state
        repeat (3) @(negedge clk);
        #1;
        check("por_uart_DO", uart_DO, 1);
        check("por_tx_busy", tx_busy, 0);
        check("por_fifo_count", fifo_count, 0);
        check("por_tx_ready", tx_ready, 0);
        #1 rst = 1'b0;

        // Idle line after reset
        idle(50);

        // Single byte
        drive(1'b1, 8'hA5, a);
        drain(200);

        // Three consecutive bytes, sent back to back
        drive(1'b1, 8'h00, a);
        drive(1'b1, 8'hFF, a);
        drive(1'b1, 8'h3C, a);
        drain(400);

        // Hold valid with six bytes during one frame; FIFO fills and stalls
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            drive(idx < 6, 8'(8'h11 + idx), a);
            if (a) idx++;
        end
        drain(600);

        // Asynchronous reset in the middle of the data bits
        drive(1'b1, 8'h55, a);
        idle(14);
        async_reset(3);
        idle(60);

        // Parity-relevant pattern
        drive(1'b1, 8'h07, a);
        drain(200);

        // Randomised traffic with bursts and gaps
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 99) < 30), 8'($urandom), a);
        end
        drain(2000);

        for (int c = 0; c < 40; c++) begin
            drive(1'b1, 8'($urandom), a);
        end
        drain(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter: the transmit direction of the FPGA comms channel, paired with the existing receive path over the same FTDI link.
- Accepts bytes over a valid/ready handshake into a small internal FIFO.
- Serialises each byte as 1 start bit, 8 data bits LSB-first, optional parity, and NSTOP stop bits.
- Runs on the 21.477 MHz PPU-derived clock, the same clock used by the receiver.

Parameters:
- NCLKS_PER_BIT, 186, clock cycles per serial bit (21 477 000 / 115200); must be >= 2.
- NSTOP, 2, number of stop bits (1 or 2).
- FIFO_DEPTH, 16, transmit FIFO entries; must be a power of two, >= 2.
- SPACE, 1, line level for idle/stop/logic-1; start bit = !SPACE.

Ports:
- clk  input  1  transmit clock (21.477 MHz)
- rst  input  1  asynchronous, active-high reset
- tx_DI  input  8  byte to transmit
- tx_valid  input  1  tx_DI is valid this cycle
- tx_ready  output  1  FIFO can accept a byte this cycle
- uart_DO  output  1  serial line to FTDI RX pin
- tx_busy  output  1  a frame is on the line, or the FIFO is non-empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO

Behaviour:
- Reset (async, active-high). While rst is high:
  - uart_DO=SPACE, tx_busy=0, fifo_count=0, state=IDLE, bit counter=0.
  - FIFO pointers are cleared; any frame in progress is abandoned with no glitch beyond an immediate return to SPACE.
- tx_ready is combinational: (fifo_count < FIFO_DEPTH) && !rst.
- Push occurs on a rising clk edge when tx_valid && tx_ready; tx_DI is written at the write pointer.
- Pop decision uses the registered fifo_count, so a byte pushed at edge k is not eligible to pop until edge k+1.
- Push and pop on the same edge leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- A push attempted while full (tx_ready=0) is ignored; the FIFO is never overwritten.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE:
  - uart_DO=SPACE.
  - If the FIFO is non-empty at an edge: load the head byte into the shift register, pop, set uart_DO=!SPACE, clear the count, go to START.
- Bit timing:
  - Every bit is held for exactly NCLKS_PER_BIT cycles; count runs 0..NCLKS_PER_BIT-1.
  - The line changes on the edge where count==NCLKS_PER_BIT-1, and count returns to 0 on that edge.
- START to DATA: drive shift[0]; bit index=0.
- DATA:
  - Each bit period, shift right and drive the next bit, with logic 1 driven as SPACE.
  - After bit 7's period, go to PARITY (if enabled) or to STOP with uart_DO=SPACE.
- STOP:
  - Held for NSTOP*NCLKS_PER_BIT cycles.
  - At the end of that period, if the FIFO is non-empty, load and pop the next byte and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Latency: a byte pushed into an empty FIFO at edge k while IDLE produces the start-bit transition at edge k+1.
- tx_busy is registered: 1 from the edge that enters START until the edge that returns to IDLE with the FIFO empty.
- Frame length is (1+8+NSTOP) bit periods, plus 1 with parity.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and drives one bit of even parity (XOR of the 8 data bits; 1 → SPACE level), held for NCLKS_PER_BIT cycles, then STOP.
- Not defined: no PARITY state; DATA goes directly to STOP. This matches the 8N2 COM-port setting.

Test Plan:
- All scenarios use NCLKS_PER_BIT=4, NSTOP=2, FIFO_DEPTH=4, no parity unless stated.
1. Reset then idle 50 cycles -> uart_DO=1, tx_busy=0, tx_ready=1, fifo_count=0 throughout.
2. Push 0xA5 at edge k -> uart_DO=0 from edge k+1 for 4 cycles; data 1,0,1,0,0,1,0,1 at 4 cycles each; high for 8 cycles; tx_busy drops at edge k+45.
3. Push 0x00, 0xFF, 0x3C on consecutive cycles -> three 44-cycle frames back-to-back with no idle gap; fifo_count peaks at 2; receive loopback yields 0x00, 0xFF, 0x3C.
4. Hold tx_valid with 6 bytes during one frame -> tx_ready=0 once fifo_count=4; only 5 bytes total are accepted (1 on line + 4 queued); no overwrite.
5. Assert rst mid-DATA of 0x55 -> uart_DO=1 immediately (async); fifo_count=0; no frame resumes after release.
6. With UART_TX_PARITY_EN, send 0x07 -> parity bit=1 (line high) for 4 cycles after bit 7; frame is 48 cycles.
